// File: rtl/btb_predictor_sa.sv
// 2-way set-associative branch target buffer: saturating direction counters, per-set LRU
// and a multi-cycle flush sweep. Define BP_STATS_EN to add update/hit/mispredict counters.
module btb_predictor_sa #(
    parameter int SETS  = 16,
    parameter int TAG_W = 8,
    parameter int CNT_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_fetch,
    output logic [31:0] predicted_target,
    output logic        prediction_taken,
    output logic        hit,
    input  logic        update_en,
    input  logic [31:0] resolved_pc,
    input  logic [31:0] resolved_target,
    input  logic        branch_taken,
    input  logic        flush_req,
`ifdef BP_STATS_EN
    output logic [31:0] stat_updates,
    output logic [31:0] stat_hits,
    output logic [31:0] stat_mispredicts,
`endif
    output logic        flush_busy
);
    localparam int IDX_W = $clog2(SETS);
    localparam logic [CNT_W-1:0] CNT_WT  = {1'b1, {(CNT_W-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_WNT = {1'b0, {(CNT_W-1){1'b1}}};

    typedef enum logic {S_IDLE, S_SWEEP} state_t;

    function automatic logic [CNT_W-1:0] f_cnt_step(input logic [CNT_W-1:0] cnt, input logic taken);
        if (taken) return (&cnt) ? cnt : cnt + CNT_W'(1);
        else       return (cnt == '0) ? cnt : cnt - CNT_W'(1);
    endfunction

    function automatic logic [31:0] f_sat_inc32(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    logic [SETS-1:0]  r_valid0, r_valid1, r_lru;
    logic [TAG_W-1:0] r_tag0 [SETS];
    logic [TAG_W-1:0] r_tag1 [SETS];
    logic [31:0]      r_tgt0 [SETS];
    logic [31:0]      r_tgt1 [SETS];
    logic [CNT_W-1:0] r_cnt0 [SETS];
    logic [CNT_W-1:0] r_cnt1 [SETS];
    state_t           r_state, w_state_nxt;
    logic [IDX_W-1:0] r_ptr;

    // Fetch-side lookup
    logic [IDX_W-1:0] w_f_idx;
    logic [TAG_W-1:0] w_f_tag;
    logic             w_f_m0, w_f_m1;
    assign w_f_idx = pc_fetch[IDX_W+1:2];
    assign w_f_tag = pc_fetch[IDX_W+2 +: TAG_W];
    assign w_f_m0  = r_valid0[w_f_idx] && (r_tag0[w_f_idx] == w_f_tag);
    assign w_f_m1  = r_valid1[w_f_idx] && (r_tag1[w_f_idx] == w_f_tag);

    always_comb begin
        hit              = rst && !flush_busy && (w_f_m0 || w_f_m1);
        prediction_taken = 1'b0;
        predicted_target = pc_fetch + 32'd4;
        if (hit) begin
            predicted_target = w_f_m0 ? r_tgt0[w_f_idx] : r_tgt1[w_f_idx];
            prediction_taken = w_f_m0 ? r_cnt0[w_f_idx][CNT_W-1] : r_cnt1[w_f_idx][CNT_W-1];
        end
    end

    // Update-side lookup and way selection; way 0 wins if both ways somehow match
    logic [IDX_W-1:0] w_u_idx;
    logic [TAG_W-1:0] w_u_tag;
    logic             w_u_m0, w_u_m1, w_u_hit, w_u_victim, w_u_way, w_upd_acc;
    logic [CNT_W-1:0] w_u_cnt_old, w_u_cnt_new;
    assign w_u_idx     = resolved_pc[IDX_W+1:2];
    assign w_u_tag     = resolved_pc[IDX_W+2 +: TAG_W];
    assign w_u_m0      = r_valid0[w_u_idx] && (r_tag0[w_u_idx] == w_u_tag);
    assign w_u_m1      = r_valid1[w_u_idx] && (r_tag1[w_u_idx] == w_u_tag);
    assign w_u_hit     = w_u_m0 || w_u_m1;
    assign w_u_victim  = !r_valid0[w_u_idx] ? 1'b0 : (!r_valid1[w_u_idx] ? 1'b1 : r_lru[w_u_idx]);
    assign w_u_way     = w_u_hit ? !w_u_m0 : w_u_victim;
    assign w_u_cnt_old = w_u_way ? r_cnt1[w_u_idx] : r_cnt0[w_u_idx];
    assign w_u_cnt_new = w_u_hit ? f_cnt_step(w_u_cnt_old, branch_taken)
                                 : (branch_taken ? CNT_WT : CNT_WNT);
    assign w_upd_acc   = update_en && (r_state == S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid0 <= '0;
            r_valid1 <= '0;
            r_lru    <= '0;
            for (int i = 0; i < SETS; i++) begin
                r_cnt0[i] <= '0;
                r_cnt1[i] <= '0;
            end
        end else if (r_state == S_SWEEP) begin
            r_valid0[r_ptr] <= 1'b0;
            r_valid1[r_ptr] <= 1'b0;
            r_lru[r_ptr]    <= 1'b0;
        end else if (update_en) begin
            if (w_u_way) begin
                r_valid1[w_u_idx] <= 1'b1;
                r_cnt1[w_u_idx]   <= w_u_cnt_new;
            end else begin
                r_valid0[w_u_idx] <= 1'b1;
                r_cnt0[w_u_idx]   <= w_u_cnt_new;
            end
            r_lru[w_u_idx] <= ~w_u_way;
        end
    end

    // Tags and targets carry no reset; validity alone decides whether they are trusted
    always_ff @(posedge clk) begin
        if (rst && w_upd_acc) begin
            if (w_u_way) begin
                r_tag1[w_u_idx] <= w_u_tag;
                r_tgt1[w_u_idx] <= resolved_target;
            end else begin
                r_tag0[w_u_idx] <= w_u_tag;
                r_tgt0[w_u_idx] <= resolved_target;
            end
        end
    end

    // Flush sequencer
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= (r_state == S_SWEEP) ? r_ptr + IDX_W'(1) : '0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (flush_req) w_state_nxt = S_SWEEP;
            S_SWEEP: if (r_ptr == IDX_W'(SETS-1)) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        flush_busy = (r_state == S_SWEEP);
    end

`ifdef BP_STATS_EN
    logic [31:0] r_stat_upd, r_stat_hit, r_stat_mis;
    logic        w_u_pred;
    assign w_u_pred = w_u_hit && w_u_cnt_old[CNT_W-1];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stat_upd <= '0;
            r_stat_hit <= '0;
            r_stat_mis <= '0;
        end else if (w_upd_acc) begin
            r_stat_upd <= f_sat_inc32(r_stat_upd);
            if (w_u_hit) r_stat_hit <= f_sat_inc32(r_stat_hit);
            if (w_u_pred != branch_taken) r_stat_mis <= f_sat_inc32(r_stat_mis);
        end
    end

    assign stat_updates     = r_stat_upd;
    assign stat_hits        = r_stat_hit;
    assign stat_mispredicts = r_stat_mis;
`endif

    logic w_unused;
    assign w_unused = &{1'b0, resolved_pc};

endmodule

// File: tb/tb_btb_predictor_sa.sv
// Scoreboard bench for btb_predictor_sa: directed scenarios then randomized traffic,
// checked against an entry-level reference model of the predictor.
module tb_btb_predictor_sa;
    localparam int SETS  = 16;
    localparam int TAG_W = 8;
    localparam int CNT_W = 2;
    localparam int IDX_W = $clog2(SETS);
    localparam int CMAX  = (1 << CNT_W) - 1;
    localparam int HALF  = 1 << (CNT_W - 1);

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc_fetch = '0, resolved_pc = '0, resolved_target = '0;
    logic        update_en = 1'b0, branch_taken = 1'b0, flush_req = 1'b0;
    logic [31:0] predicted_target;
    logic        prediction_taken, hit, flush_busy;
`ifdef BP_STATS_EN
    logic [31:0] stat_updates, stat_hits, stat_mispredicts;
`endif

    btb_predictor_sa #(.SETS(SETS), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .pc_fetch(pc_fetch),
        .predicted_target(predicted_target), .prediction_taken(prediction_taken), .hit(hit),
        .update_en(update_en), .resolved_pc(resolved_pc), .resolved_target(resolved_target),
        .branch_taken(branch_taken), .flush_req(flush_req),
`ifdef BP_STATS_EN
        .stat_updates(stat_updates), .stat_hits(stat_hits), .stat_mispredicts(stat_mispredicts),
`endif
        .flush_busy(flush_busy)
    );

    always #5 clk = ~clk;

    typedef struct { bit v; bit [TAG_W-1:0] tag; bit [31:0] tgt; int cnt; } way_t;
    typedef struct {
        bit hit; bit tk; bit [31:0] tgt; bit busy;
`ifdef BP_STATS_EN
        longint su; longint sh; longint sm;
`endif
        int cyc;
    } exp_t;

    way_t   m_way [SETS][2];
    int     m_lru [SETS];
    int     m_flush_left;
    longint m_su, m_sh, m_sm;
    exp_t   q[$];
    int     checks = 0, errors = 0, cyc = 0;

    function automatic bit [TAG_W-1:0] tag_of(bit [31:0] pc);
        return pc[IDX_W+2 +: TAG_W];
    endfunction

    function automatic int idx_of(bit [31:0] pc);
        return int'(pc[IDX_W+1:2]);
    endfunction

    function automatic int m_find(bit [31:0] pc);
        int s = idx_of(pc);
        for (int w = 0; w < 2; w++)
            if (m_way[s][w].v && m_way[s][w].tag == tag_of(pc)) return w;
        return -1;
    endfunction

    function automatic void m_reset();
        for (int s = 0; s < SETS; s++) begin
            m_lru[s] = 0;
            for (int w = 0; w < 2; w++) begin
                m_way[s][w].v = 0;
                m_way[s][w].cnt = 0;
            end
        end
        m_flush_left = 0;
        m_su = 0; m_sh = 0; m_sm = 0;
    endfunction

    function automatic exp_t m_expect(bit [31:0] pc, bit rn);
        exp_t e;
        int   w;
        e.busy = (m_flush_left > 0);
        w = m_find(pc);
        e.hit = rn && !e.busy && (w >= 0);
        e.tk  = e.hit && (m_way[idx_of(pc)][w].cnt >= HALF);
        e.tgt = e.hit ? m_way[idx_of(pc)][w].tgt : pc + 32'd4;
`ifdef BP_STATS_EN
        e.su = m_su; e.sh = m_sh; e.sm = m_sm;
`endif
        e.cyc = cyc;
        return e;
    endfunction

    function automatic void m_update(bit [31:0] rpc, bit [31:0] rtgt, bit tk);
        int  s = idx_of(rpc);
        int  w = m_find(rpc);
        bit  pred = (w >= 0) && (m_way[s][w].cnt >= HALF);
        if (m_su < 64'hFFFF_FFFF) m_su++;
        if (w >= 0 && m_sh < 64'hFFFF_FFFF) m_sh++;
        if (pred != tk && m_sm < 64'hFFFF_FFFF) m_sm++;
        if (w >= 0) begin
            m_way[s][w].cnt = tk ? ((m_way[s][w].cnt < CMAX) ? m_way[s][w].cnt + 1 : CMAX)
                                 : ((m_way[s][w].cnt > 0) ? m_way[s][w].cnt - 1 : 0);
        end else begin
            w = !m_way[s][0].v ? 0 : (!m_way[s][1].v ? 1 : m_lru[s]);
            m_way[s][w].v   = 1;
            m_way[s][w].tag = tag_of(rpc);
            m_way[s][w].cnt = tk ? HALF : HALF - 1;
        end
        m_way[s][w].tgt = rtgt;
        m_lru[s] = 1 - w;
    endfunction

    function automatic void m_edge(bit upd, bit [31:0] rpc, bit [31:0] rtgt, bit tk, bit fl, bit rn);
        if (!rn) begin
            m_reset();
        end else if (m_flush_left > 0) begin
            int s = SETS - m_flush_left;
            m_way[s][0].v = 0;
            m_way[s][1].v = 0;
            m_lru[s] = 0;
            m_flush_left--;
        end else begin
            if (upd) m_update(rpc, rtgt, tk);
            if (fl) m_flush_left = SETS;
        end
    endfunction

    // One cycle: drive inputs, queue the expected outputs for this cycle, advance the model at the edge
    task automatic step(input bit [31:0] pc, input bit upd, input bit [31:0] rpc,
                        input bit [31:0] rtgt, input bit tk, input bit fl, input bit rn);
        pc_fetch = pc; update_en = upd; resolved_pc = rpc; resolved_target = rtgt;
        branch_taken = tk; flush_req = fl; rst = rn;
        q.push_back(m_expect(pc, rn));
        @(posedge clk);
        m_edge(upd, rpc, rtgt, tk, fl, rn);
        cyc++;
        #1;
    endtask

    task automatic look(input bit [31:0] pc);
        step(pc, 0, 32'h0, 32'h0, 0, 0, 1);
    endtask

    task automatic upd(input bit [31:0] rpc, input bit [31:0] rtgt, input bit tk);
        step(rpc, 1, rpc, rtgt, tk, 0, 1);
    endtask

    function automatic bit [31:0] rand_pc();
        bit [31:0] hi = ($urandom_range(0, 1) == 1) ? ($urandom & 32'hFFFF_C000) : 32'h0;
        return hi | (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 3)) << 2)
                  | 32'($urandom_range(0, 3));
    endfunction

    // Monitor: one output set per cycle, compared mid-cycle on the falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (hit !== e.hit || prediction_taken !== e.tk || predicted_target !== e.tgt
                    || flush_busy !== e.busy) begin
                    errors++;
                    $display("FAIL lookup cyc=%0d pc=%h actual hit=%b tk=%b tgt=%h busy=%b required hit=%b tk=%b tgt=%h busy=%b",
                             e.cyc, pc_fetch, hit, prediction_taken, predicted_target, flush_busy,
                             e.hit, e.tk, e.tgt, e.busy);
                end
`ifdef BP_STATS_EN
                checks++;
                if (stat_updates !== 32'(e.su) || stat_hits !== 32'(e.sh) || stat_mispredicts !== 32'(e.sm)) begin
                    errors++;
                    $display("FAIL stats cyc=%0d actual %0d/%0d/%0d required %0d/%0d/%0d",
                             e.cyc, stat_updates, stat_hits, stat_mispredicts, e.su, e.sh, e.sm);
                end
`endif
            end
        end
    end

    initial begin
        int waited;
        m_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // 1: reset state, then release
        step(32'h100, 0, 0, 0, 0, 0, 0);
        look(32'h100);
        // 2: allocate then train down
        upd(32'h100, 32'h80, 1);
        look(32'h100);
        upd(32'h100, 32'h80, 0);
        upd(32'h100, 32'h80, 0);
        look(32'h100);
        // 3: three tags in set 0 evict the oldest
        step(32'h0, 0, 0, 0, 0, 0, 0);
        upd(32'h100, 32'h1000, 1);
        upd(32'h140, 32'h2000, 1);
        upd(32'h180, 32'h3000, 1);
        look(32'h100); look(32'h140); look(32'h180);
        // 4: counter saturation and hysteresis
        for (int i = 0; i < 4; i++) upd(32'h200, 32'h400, 1);
        look(32'h200);
        upd(32'h200, 32'h400, 0);
        look(32'h200);
        upd(32'h200, 32'h400, 0);
        look(32'h200);
        // 5: flush sweep ignores updates, then everything misses
        upd(32'h100, 32'h500, 1);
        upd(32'h204, 32'h600, 1);
        step(32'h100, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 16; i++) begin
            if (i == 3) step(32'h300, 1, 32'h300, 32'h700, 1, 0, 1);
            else look(32'h100);
        end
        look(32'h100); look(32'h204); look(32'h300);
        // 6: reset in the fifth busy cycle aborts the sweep
        upd(32'h100, 32'h500, 1);
        step(32'h100, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 4; i++) look(32'h100);
        step(32'h100, 0, 0, 0, 0, 0, 0);
        look(32'h100); look(32'h140);
        // Randomized traffic, including held flush requests and occasional resets
        for (int i = 0; i < 3000; i++) begin
            bit [31:0] rpc = rand_pc();
            int r = $urandom_range(0, 199);
            step(($urandom_range(0, 1) == 1) ? rpc : rand_pc(), $urandom_range(0, 9) < 6, rpc,
                 $urandom, $urandom_range(0, 2) != 0, r < 5, r != 199);
        end
        pc_fetch = 32'h0; update_en = 0; flush_req = 0; rst = 1;
        waited = 0;
        while (q.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain actual %0d pending required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
